// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM port between N_REQ requesters via a registered one-hot grant.
// Optional build macro SRAM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 highest) instead of round-robin.
module sram_arbiter #(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 21,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          rd,
  input  logic [N_REQ-1:0]          wr,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          ready,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ready
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  typedef enum logic {
    S_IDLE,
    S_OWNED
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [N_REQ-1:0]   r_grant;
  logic [IW-1:0]      r_owner;
  logic [7:0]         r_burst;

  logic [ADDR_W-1:0]  w_addr  [N_REQ];
  logic [DATA_W-1:0]  w_wdata [N_REQ];

  logic               w_owned;
  logic               w_stb;
  logic               w_done;
  logic               w_waiting;
  logic               w_release;
  logic               w_start;
  logic               w_found;
  logic [IW-1:0]      w_sel;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign w_addr[g]  = addr[g*ADDR_W +: ADDR_W];
    assign w_wdata[g] = wdata[g*DATA_W +: DATA_W];
  end

  assign grant   = r_grant;
  assign w_owned = (r_state == S_OWNED);
  assign w_stb   = rd[r_owner] | wr[r_owner];
  assign w_done  = w_owned & mem_ready & w_stb;
  assign w_start = (r_state == S_IDLE) & w_found;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // Only a lower-index (higher priority) waiter may force a release.
  assign w_waiting = |(req & (r_grant - N_REQ'(1)));

  // Lowest-index requesting bit wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req[i]) begin
        w_found = 1'b1;
        w_sel   = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] r_last;

  assign w_waiting = |(req & ~r_grant);

  // Round-robin search starting just after the previous owner.
  always_comb begin
    int w_idx;
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = (int'(r_last) + k) % N_REQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = IW'(w_idx);
      end
    end
  end

  // Remember who owned last, for fairness.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_last <= IW'(N_REQ - 1);
    else if (w_release)
      r_last <= r_owner;
  end
`endif

  // Release only when the owner has no strobe up, so no transfer is cut short.
  assign w_release = w_owned & ~w_stb &
                     (~req[r_owner] |
                      ((r_burst == BURST_MAX) & w_waiting));

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_found)   w_next_state = S_OWNED;
      S_OWNED: if (w_release) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // One-hot grant and owner index, set on arbitration, cleared on release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant <= '0;
      r_owner <= '0;
    end else if (w_start) begin
      r_grant <= N_REQ'(1) << w_sel;
      r_owner <= w_sel;
    end else if (w_release) begin
      r_grant <= '0;
    end
  end

  // Completed transfers in the current tenure, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_burst <= '0;
    else if (w_start)
      r_burst <= '0;
    else if (w_done && r_burst < BURST_MAX)
      r_burst <= r_burst + 8'd1;
  end

  // Contention-free mux from the owner's slice to the SRAM port.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    ready     = '0;
    rdata     = '0;
    if (w_owned) begin
      mem_addr  = w_addr[r_owner];
      mem_wdata = w_wdata[r_owner];
      mem_write = wr[r_owner];
      mem_read  = rd[r_owner] & ~wr[r_owner];
      ready     = w_done ? r_grant : '0;
      rdata     = mem_rdata;
    end
  end

endmodule
